// File: rtl/conv_result_streamer.sv
// Streams a captured OUT x OUT convolution result one pixel per ready/valid
// transfer in raster order, flagging frames that arrive while one is in flight.
module conv_result_streamer #(
    parameter int OUT   = 3,
    parameter int PIX_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [OUT*OUT*PIX_W-1:0] result_flat,
    input  logic                     done_in,
    output logic [PIX_W-1:0]         px_data,
    output logic                     px_valid,
    input  logic                     px_ready,
    output logic                     px_last,
    output logic [15:0]              px_row,
    output logic [15:0]              px_col,
    output logic                     busy,
    output logic                     frame_sent,
    output logic                     overrun
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    localparam int          FLAT_W   = OUT * OUT * PIX_W;
    localparam logic [15:0] LAST_IDX = 16'(OUT - 1);

    state_e              state_q;
    logic [FLAT_W-1:0]   shadow_q;
    logic                done_q;
    logic                start_s;
    logic [15:0]         row_d;
    logic [15:0]         col_d;
    logic [31:0]         pix_idx_d;

    // Rising-edge detect on done_in and raster-order successor of the current pixel.
    always_comb begin
        start_s = done_in & ~done_q;
        if (px_col == LAST_IDX) begin
            col_d = 16'd0;
            row_d = px_row + 16'd1;
        end else begin
            col_d = px_col + 16'd1;
            row_d = px_row;
        end
        pix_idx_d = 32'(row_d) * 32'(OUT) + 32'(col_d);
    end

    // Streaming FSM; every output is a register so it holds across stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shadow_q   <= '0;
            done_q     <= 1'b0;
            px_data    <= '0;
            px_valid   <= 1'b0;
            px_last    <= 1'b0;
            px_row     <= 16'd0;
            px_col     <= 16'd0;
            busy       <= 1'b0;
            frame_sent <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            done_q <= done_in;
            case (state_q)
                S_IDLE: begin
                    if (start_s) begin
                        shadow_q <= result_flat;
                        px_row   <= 16'd0;
                        px_col   <= 16'd0;
                        px_data  <= result_flat[PIX_W-1:0];
                        px_last  <= (LAST_IDX == 16'd0);
                        px_valid <= 1'b1;
                        busy     <= 1'b1;
                        state_q  <= S_SEND;
                    end else begin
                        px_valid   <= 1'b0;
                        px_last    <= 1'b0;
                        busy       <= 1'b0;
                        frame_sent <= 1'b0;
                    end
                end
                S_SEND: begin
                    // A new frame here is dropped; the one in flight is untouched.
                    if (start_s) begin
                        overrun <= 1'b1;
                    end
                    if (px_ready) begin
                        if (px_last) begin
                            px_valid   <= 1'b0;
                            px_last    <= 1'b0;
                            frame_sent <= 1'b1;
                            state_q    <= S_FIN;
                        end else begin
                            px_row  <= row_d;
                            px_col  <= col_d;
                            px_data <= shadow_q[pix_idx_d*PIX_W +: PIX_W];
                            px_last <= (row_d == LAST_IDX) && (col_d == LAST_IDX);
                        end
                    end
                end
                S_FIN: begin
                    if (start_s) begin
                        overrun <= 1'b1;
                    end
                    frame_sent <= 1'b0;
                    busy       <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    px_valid   <= 1'b0;
                    px_last    <= 1'b0;
                    busy       <= 1'b0;
                    frame_sent <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_result_streamer.sv
// Randomised bench for conv_result_streamer: a pixel-index reference model is
// compared against the DUT every cycle, plus directed frames with literal checks.
module tb_conv_result_streamer;

    localparam int OUT   = 3;
    localparam int PIX_W = 16;
    localparam int NPIX  = OUT * OUT;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NPIX*PIX_W-1:0]   result_flat;
    logic                    done_in;
    logic [PIX_W-1:0]        px_data;
    logic                    px_valid;
    logic                    px_ready;
    logic                    px_last;
    logic [15:0]             px_row;
    logic [15:0]             px_col;
    logic                    busy;
    logic                    frame_sent;
    logic                    overrun;

    logic [PIX_W-1:0]        result_flat1;
    logic [PIX_W-1:0]        px_data1;
    logic                    px_valid1;
    logic                    px_ready1;
    logic                    px_last1;
    logic [15:0]             px_row1;
    logic [15:0]             px_col1;
    logic                    busy1;
    logic                    frame_sent1;
    logic                    overrun1;

    int checks = 0;
    int errors = 0;

    conv_result_streamer #(.OUT(OUT), .PIX_W(PIX_W)) dut (
        .clk(clk), .rst(rst), .result_flat(result_flat), .done_in(done_in),
        .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
        .px_last(px_last), .px_row(px_row), .px_col(px_col), .busy(busy),
        .frame_sent(frame_sent), .overrun(overrun)
    );

    conv_result_streamer #(.OUT(1), .PIX_W(PIX_W)) dut1 (
        .clk(clk), .rst(rst), .result_flat(result_flat1), .done_in(done_in),
        .px_data(px_data1), .px_valid(px_valid1), .px_ready(px_ready1),
        .px_last(px_last1), .px_row(px_row1), .px_col(px_col1), .busy(busy1),
        .frame_sent(frame_sent1), .overrun(overrun1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: frame = array of pixels, position = single pixel index.
    int unsigned m_pix [NPIX];
    int          m_k;
    bit          m_valid, m_fin, m_ov, m_prev;
    bit          chk_en = 1'b0;

    // Observed DUT transfers and frame_sent pulses for the directed checks.
    int unsigned got_q [$];
    int          n_frames = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst && px_valid && px_ready) got_q.push_back(px_data);
            if (!rst && frame_sent) n_frames++;
            if (rst) begin
                m_valid = 1'b0; m_fin = 1'b0; m_ov = 1'b0; m_prev = 1'b0; m_k = 0;
            end else begin
                bit start;
                start  = done_in && !m_prev;
                m_prev = done_in;
                if (m_fin) begin
                    m_fin = 1'b0;
                    if (start) m_ov = 1'b1;
                end else if (m_valid) begin
                    if (start) m_ov = 1'b1;
                    if (px_ready) begin
                        if (m_k == NPIX - 1) begin
                            m_valid = 1'b0;
                            m_fin   = 1'b1;
                        end else begin
                            m_k++;
                        end
                    end
                end else if (start) begin
                    for (int i = 0; i < NPIX; i++) m_pix[i] = result_flat[i*PIX_W +: PIX_W];
                    m_k     = 0;
                    m_valid = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("px_valid", 32'(px_valid), 32'(m_valid));
                chk("busy", 32'(busy), 32'(m_valid | m_fin));
                chk("frame_sent", 32'(frame_sent), 32'(m_fin));
                chk("overrun", 32'(overrun), 32'(m_ov));
                if (m_valid) begin
                    chk("px_data", 32'(px_data), m_pix[m_k]);
                    chk("px_row", 32'(px_row), 32'(m_k / OUT));
                    chk("px_col", 32'(px_col), 32'(m_k % OUT));
                    chk("px_last", 32'(px_last), 32'(m_k == NPIX - 1));
                end else begin
                    chk("px_last_idle", 32'(px_last), 32'd0);
                end
            end
        end
    end

    task automatic load_ramp();
        for (int i = 0; i < NPIX; i++) result_flat[i*PIX_W +: PIX_W] = PIX_W'(i + 1);
    endtask

    task automatic chk_seq(input string name);
        chk({name, "_len"}, 32'(got_q.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < got_q.size()) chk(name, got_q[i], 32'(i + 1));
        end
    endtask

    initial begin
        rst = 1'b1; done_in = 1'b0; px_ready = 1'b0; px_ready1 = 1'b1;
        result_flat1 = 16'hABCD;
        load_ramp();
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_valid", 32'(px_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_data", 32'(px_data), 32'd0);
        chk("rst_row", 32'(px_row), 32'd0);
        chk("rst_col", 32'(px_col), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full-speed frame, then done_in held high for 50 cycles.
        got_q.delete(); n_frames = 0;
        px_ready = 1'b1; done_in = 1'b1;
        @(negedge clk);
        chk("lat_valid", 32'(px_valid), 32'd1);
        chk("lat_data", 32'(px_data), 32'd1);
        chk("out1_valid", 32'(px_valid1), 32'd1);
        chk("out1_last", 32'(px_last1), 32'd1);
        chk("out1_data", 32'(px_data1), 32'hABCD);
        @(negedge clk);
        chk("out1_fs", 32'(frame_sent1), 32'd1);
        chk("out1_valid_off", 32'(px_valid1), 32'd0);
        repeat (50) @(negedge clk);
        chk_seq("seq_fast");
        chk("frames_fast", 32'(n_frames), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        done_in = 1'b0;
        repeat (2) @(negedge clk);

        // Stalled frame with the source overwritten after capture.
        got_q.delete(); n_frames = 0;
        done_in = 1'b1;
        @(negedge clk);
        result_flat = '1;
        for (int i = 0; i < 60; i++) begin
            px_ready = (i % 3 == 0);
            @(negedge clk);
        end
        chk_seq("seq_stall");
        chk("frames_stall", 32'(n_frames), 32'd1);
        done_in = 1'b0; px_ready = 1'b1;
        load_ramp();
        repeat (2) @(negedge clk);

        // Second frame while pixel 4 is on the bus.
        got_q.delete(); n_frames = 0;
        done_in = 1'b1;
        repeat (4) @(negedge clk);
        chk("ovr_at_px4", 32'(px_data), 32'd4);
        px_ready = 1'b0; done_in = 1'b0;
        @(negedge clk);
        done_in = 1'b1;
        @(negedge clk);
        px_ready = 1'b1;
        repeat (30) @(negedge clk);
        chk_seq("seq_ovr");
        chk("frames_ovr", 32'(n_frames), 32'd1);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        done_in = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-frame with done_in held high.
        got_q.delete(); n_frames = 0;
        done_in = 1'b1;
        repeat (6) @(negedge clk);
        chk("pre_rst_data", 32'(px_data), 32'd6);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(px_valid), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        chk("mid_rst_row", 32'(px_row), 32'd0);
        chk("mid_rst_data", 32'(px_data), 32'd0);
        chk("abort_no_fs", 32'(n_frames), 32'd0);
        got_q.delete();
        rst = 1'b0;
        @(negedge clk);
        chk("resend_valid", 32'(px_valid), 32'd1);
        chk("resend_data", 32'(px_data), 32'd1);
        repeat (30) @(negedge clk);
        chk_seq("seq_resend");
        chk("frames_resend", 32'(n_frames), 32'd1);

        // Randomised traffic, including sources changing and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            for (int w = 0; w < NPIX; w++) result_flat[w*PIX_W +: PIX_W] = PIX_W'($urandom);
            px_ready = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) done_in = ~done_in;
            rst = ($urandom_range(400) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_result_streamer.md
CONV_RESULT_STREAMER -- requirements
Module: conv_result_streamer

Interface
REQ-001 SHALL have parameter OUT, default 3, meaning output feature-map edge length (OUT x OUT pixels).
REQ-002 SHALL have parameter PIX_W, default 16, meaning width of one result pixel.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port result_flat  input  OUT*OUT*PIX_W  the packed convolution result; pixel k = row*OUT+col occupies bits [k*PIX_W +: PIX_W].
REQ-006 SHALL have port done_in  input  1  the level "result complete" flag from the convolution engine; it may stay high indefinitely.
REQ-007 SHALL have port px_data  output  PIX_W  the streamed pixel value.
REQ-008 SHALL have port px_valid  output  1  px_data/px_row/px_col/px_last are valid.
REQ-009 SHALL have port px_ready  input  1  the downstream consumer accepts the pixel.
REQ-010 SHALL have port px_last  output  1  high with the final pixel (k = OUT*OUT-1).
REQ-011 SHALL have port px_row  output  16  the row index of the current pixel.
REQ-012 SHALL have port px_col  output  16  the column index of the current pixel.
REQ-013 SHALL have port busy  output  1  high while a frame is held or being sent.
REQ-014 SHALL have port frame_sent  output  1  a one-cycle pulse after the last pixel transfers.
REQ-015 SHALL have port overrun  output  1  a sticky flag: a new frame arrived while busy.

Function
REQ-016 SHALL register done_in into done_d each cycle; start event = done_in & ~done_d.
REQ-017 SHALL implement FSM states IDLE, SEND, FIN.
REQ-018 In IDLE, a start event SHALL copy result_flat into an internal shadow register, clear row/col to 0, and move to SEND at that same edge.
REQ-019 Latency: start event sampled at edge N SHALL give px_valid=1 with pixel 0 from shadow during the cycle after edge N.
REQ-020 In SEND, px_valid SHALL be 1; a transfer occurs on an edge where px_valid & px_ready.
REQ-021 While px_valid & ~px_ready, px_data, px_row, px_col and px_last SHALL hold stable.
REQ-022 On a transfer with col<OUT-1, col SHALL increment; with col=OUT-1, col SHALL go to 0 and row SHALL increment (raster order).
REQ-023 px_data SHALL equal shadow bits [(px_row*OUT+px_col)*PIX_W +: PIX_W]; it SHALL never read result_flat directly after capture.
REQ-024 px_last SHALL be 1 exactly when px_row=OUT-1 and px_col=OUT-1 in SEND.
REQ-025 A transfer with px_last=1 SHALL move SEND to FIN; FIN SHALL assert frame_sent for one cycle with px_valid=0, then go to IDLE.
REQ-026 busy SHALL be 1 in SEND and FIN, and 0 in IDLE.
REQ-027 A start event in SEND or FIN, including one coincident with the last transfer, SHALL set overrun and SHALL NOT disturb the frame in flight or the shadow; that frame is dropped.
REQ-028 overrun SHALL clear only on reset.
REQ-029 px_ready while px_valid=0 SHALL have no effect.
REQ-030 OUT=1 SHALL send one pixel with px_last=1.

Reset
REQ-031 With rst=1 at a rising edge, state SHALL go to IDLE and px_valid, px_last, busy, frame_sent, overrun, done_d, px_row, px_col, px_data and the shadow SHALL go to 0.
REQ-032 Reset mid-frame SHALL abort the frame with no frame_sent.
REQ-033 Because done_d resets to 0, a done_in held high through reset release SHALL produce a start event on the first non-reset edge, and the frame SHALL be resent.

Verification
REQ-034 OUT=3, pixels 0x0001..0x0009, done_in rises, px_ready=1 -> nine consecutive transfers 1..9, row/col (0,0)..(2,2), px_last only on 9, then frame_sent pulse, busy=0.
REQ-035 Same frame, px_ready toggling 1,0,0,1,... -> outputs hold through stalls, order unchanged, exactly nine transfers.
REQ-036 result_flat changed to all 0xFFFF after capture -> streamed values are still 1..9.
REQ-037 Second done_in rising edge during pixel 4 -> overrun=1 and stays 1, current frame completes intact, and no second frame is sent.
REQ-038 rst pulsed after pixel 5 with done_in held high -> outputs cleared, no frame_sent, then a full resend 1..9 starting the cycle after the first post-reset edge.
REQ-039 done_in held high for 50 cycles after a frame -> exactly one frame is sent.
